// File: rtl/lib_arbiter_pkg.sv
// Shared types and constants for the pixel event arbitration logic.
package lib_arbiter_pkg;

  localparam int unsigned POLARITY = 2;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    ACK
  } sched_state_t;

  localparam logic [POLARITY-1:0] POL_ON  = 2'b10;
  localparam logic [POLARITY-1:0] POL_OFF = 2'b01;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set bit at or above rr_ptr_i, wrapping.
module rr_priority_pick #(
  parameter int unsigned NUM_PIX = 16,
  parameter int unsigned IDX_W   = $clog2(NUM_PIX)
) (
  input  logic [NUM_PIX-1:0] active_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [2*NUM_PIX-1:0] doubled;
  logic [NUM_PIX-1:0]   rotated;
  logic [IDX_W-1:0]     offset;

  // Rotating the doubled vector puts rr_ptr_i at bit 0.
  assign doubled = {active_i, active_i} >> rr_ptr_i;
  assign rotated = doubled[NUM_PIX-1:0];

  always_comb begin
    found_o = 1'b0;
    offset  = '0;
    for (int i = NUM_PIX - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        found_o = 1'b1;
        offset  = IDX_W'(i);
      end
    end
  end

  // NUM_PIX is a power of two, so the add wraps modulo NUM_PIX for free.
  assign idx_o = offset + rr_ptr_i;

endmodule

// File: rtl/pixel_event_scheduler.sv
// Round-robin scheduler sharing one timestamped event channel among NUM_PIX pixels,
// with a one-cycle acknowledge back to the served pixel.
module pixel_event_scheduler
  import lib_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PIX = 16,
  parameter int unsigned IDX_W   = $clog2(NUM_PIX),
  parameter int unsigned TS_W    = 16
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               enable_i,
  input  logic [NUM_PIX-1:0][POLARITY-1:0]   req_i,
  output logic [NUM_PIX-1:0]                 ack_o,
  output logic                               evt_valid_o,
  input  logic                               evt_ready_i,
  output logic [IDX_W-1:0]                   evt_idx_o,
  output logic                               evt_pol_o,
  output logic [TS_W-1:0]                    evt_ts_o,
  output logic                               busy_o,
  output logic [7:0]                         err_cnt_o
);

  sched_state_t          state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [TS_W-1:0]       ts_cnt_q;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  pol_q, pol_d;
  logic [TS_W-1:0]       ts_q, ts_d;
  logic [NUM_PIX-1:0]    ack_q, ack_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic [7:0]            err_q, err_d;

  logic [NUM_PIX-1:0]    active;
  logic                  found;
  logic [IDX_W-1:0]      pick_idx;
  logic [POLARITY-1:0]   pick_req;

  always_comb begin
    for (int i = 0; i < NUM_PIX; i++) begin
      active[i] = |req_i[i];
    end
  end

  rr_priority_pick #(
    .NUM_PIX (NUM_PIX),
    .IDX_W   (IDX_W)
  ) u_pick (
    .active_i (active),
    .rr_ptr_i (rr_ptr_q),
    .found_o  (found),
    .idx_o    (pick_idx)
  );

  assign pick_req = req_i[pick_idx];

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    pol_d    = pol_q;
    ts_d     = ts_q;
    err_d    = err_q;
    ack_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (enable_i && found) begin
          state_d = SEND;
          idx_d   = pick_idx;
          pol_d   = (pick_req == POL_ON);
          ts_d    = ts_cnt_q;
          // Both polarities at once is illegal: reported as OFF and counted.
          if (pick_req == (POL_ON | POL_OFF) && err_q != 8'hff) begin
            err_d = err_q + 8'd1;
          end
        end
      end
      SEND: begin
        if (evt_ready_i) begin
          state_d = ACK;
          ack_d   = NUM_PIX'(1) << idx_q;
        end
      end
      ACK: begin
        state_d  = IDLE;
        rr_ptr_d = idx_q + IDX_W'(1);
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == SEND);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      ts_cnt_q <= '0;
      idx_q    <= '0;
      pol_q    <= 1'b0;
      ts_q     <= '0;
      ack_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      ts_cnt_q <= ts_cnt_q + TS_W'(1);
      idx_q    <= idx_d;
      pol_q    <= pol_d;
      ts_q     <= ts_d;
      ack_q    <= ack_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign ack_o       = ack_q;
  assign evt_valid_o = valid_q;
  assign evt_idx_o   = idx_q;
  assign evt_pol_o   = pol_q;
  assign evt_ts_o    = ts_q;
  assign busy_o      = busy_q;
  assign err_cnt_o   = err_q;

endmodule

// File: tb/tb_pixel_event_scheduler.sv
// Directed bench for pixel_event_scheduler with an event-level reference model
// compared on every falling clock edge.
module tb_pixel_event_scheduler;

  localparam int NPIX  = 16;
  localparam int IDXW  = 4;
  localparam int TSW   = 4;

  logic                  clk_i = 1'b0;
  logic                  reset_i;
  logic                  enable_i;
  logic [NPIX-1:0][1:0]  req_i;
  logic [NPIX-1:0]       ack_o;
  logic                  evt_valid_o;
  logic                  evt_ready_i;
  logic [IDXW-1:0]       evt_idx_o;
  logic                  evt_pol_o;
  logic [TSW-1:0]        evt_ts_o;
  logic                  busy_o;
  logic [7:0]            err_cnt_o;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  pixel_event_scheduler #(
    .NUM_PIX (NPIX),
    .IDX_W   (IDXW),
    .TS_W    (TSW)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .enable_i    (enable_i),
    .req_i       (req_i),
    .ack_o       (ack_o),
    .evt_valid_o (evt_valid_o),
    .evt_ready_i (evt_ready_i),
    .evt_idx_o   (evt_idx_o),
    .evt_pol_o   (evt_pol_o),
    .evt_ts_o    (evt_ts_o),
    .busy_o      (busy_o),
    .err_cnt_o   (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: one pending event, one ack cycle, then the pointer moves past it.
  int m_ts, m_ptr, m_idx, m_evt_ts, m_err, m_ack_idx, cyc;
  bit m_pend, m_ackv, m_pol;

  function automatic int pick(input int ptr);
    for (int k = 0; k < NPIX; k++) begin
      if (req_i[(ptr + k) % NPIX] != 2'b00) return (ptr + k) % NPIX;
    end
    return -1;
  endfunction

  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      m_ts <= 0; m_ptr <= 0; m_idx <= 0; m_evt_ts <= 0; m_err <= 0;
      m_ack_idx <= 0; m_pend <= 0; m_ackv <= 0; m_pol <= 0; cyc <= 0;
    end else begin
      cyc  <= cyc + 1;
      m_ts <= (m_ts + 1) % (1 << TSW);
      if (m_ackv) begin
        m_ackv <= 0;
        m_ptr  <= (m_ack_idx + 1) % NPIX;
      end else if (m_pend) begin
        if (evt_ready_i) begin
          m_pend    <= 0;
          m_ackv    <= 1;
          m_ack_idx <= m_idx;
        end
      end else if (enable_i && pick(m_ptr) >= 0) begin
        m_pend   <= 1;
        m_idx    <= pick(m_ptr);
        m_pol    <= (req_i[pick(m_ptr)] == 2'b10);
        m_evt_ts <= m_ts;
        if (req_i[pick(m_ptr)] == 2'b11 && m_err < 255) m_err <= m_err + 1;
      end
    end
  end

  always @(negedge clk_i) begin
    if (cmp_en) begin
      check("cmp_valid", 32'(evt_valid_o), 32'(m_pend));
      check("cmp_busy", 32'(busy_o), 32'(m_pend | m_ackv));
      check("cmp_ack", 32'(ack_o), m_ackv ? (32'd1 << m_ack_idx) : 32'd0);
      check("cmp_idx", 32'(evt_idx_o), 32'(m_idx));
      check("cmp_pol", 32'(evt_pol_o), 32'(m_pol));
      check("cmp_ts", 32'(evt_ts_o), 32'(m_evt_ts));
      check("cmp_err", 32'(err_cnt_o), 32'(m_err));
    end
  end

  task automatic wait_valid(input string name, input int max_cycles);
    int n = 0;
    @(negedge clk_i);
    while (!evt_valid_o && n < max_cycles) begin
      @(negedge clk_i);
      n++;
    end
    check(name, 32'(evt_valid_o), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    req_i = '0;
    evt_ready_i = 1'b1;
    enable_i = 1'b1;
    repeat (n) @(negedge clk_i);
  endtask

  int fair_order [4] = '{15, 2, 7, 15};
  int acks;

  initial begin
    reset_i = 1'b1; enable_i = 1'b1; req_i = '0; evt_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst_valid", 32'(evt_valid_o), 0);
    check("rst_ack", 32'(ack_o), 0);
    check("rst_err", 32'(err_cnt_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    reset_i = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk_i);

    // Single request on pixel 3, then pointer lands on 4.
    req_i[3] = 2'b10;
    @(negedge clk_i);
    check("single_lat", 32'(evt_valid_o), 1);
    check("single_idx", 32'(evt_idx_o), 3);
    check("single_pol", 32'(evt_pol_o), 1);
    @(negedge clk_i);
    check("single_ack", 32'(ack_o), 32'h0008);
    req_i[4] = 2'b10;
    @(negedge clk_i);
    check("single_ack_clr", 32'(ack_o), 0);
    @(negedge clk_i);
    check("ptr4_valid", 32'(evt_valid_o), 1);
    check("ptr4_idx", 32'(evt_idx_o), 4);
    idle_cycles(4);

    // Fairness with wrap: serve pixel 7 first so the pointer sits at 8.
    req_i[7] = 2'b01;
    wait_valid("fair_pre_valid", 10);
    check("fair_pre_idx", 32'(evt_idx_o), 7);
    @(negedge clk_i);
    req_i[2] = 2'b10; req_i[15] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      wait_valid("fair_valid", 10);
      check("fair_idx", 32'(evt_idx_o), 32'(fair_order[i]));
      @(negedge clk_i);
      check("fair_ack", 32'(ack_o), 32'd1 << fair_order[i]);
    end
    idle_cycles(4);

    // Backpressure on pixel 5.
    evt_ready_i = 1'b0;
    req_i[5] = 2'b10;
    wait_valid("bp_valid", 10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("bp_hold_valid", 32'(evt_valid_o), 1);
      check("bp_hold_idx", 32'(evt_idx_o), 5);
      check("bp_no_ack", 32'(ack_o), 0);
    end
    evt_ready_i = 1'b1;
    @(negedge clk_i);
    check("bp_ack", 32'(ack_o), 32'h0020);
    idle_cycles(4);

    // Illegal request on pixel 0, repeated until the error counter saturates.
    req_i[0] = 2'b11;
    wait_valid("ill_valid", 10);
    check("ill_pol", 32'(evt_pol_o), 0);
    check("ill_err1", 32'(err_cnt_o), 1);
    acks = 0;
    for (int n = 0; n < 2000 && acks < 300; n++) begin
      @(negedge clk_i);
      if (ack_o[0]) acks++;
    end
    check("ill_events", 32'(acks), 300);
    idle_cycles(4);
    check("ill_err_sat", 32'(err_cnt_o), 255);

    // Reset while an event is pending.
    evt_ready_i = 1'b0;
    req_i[4] = 2'b01;
    wait_valid("rstm_valid", 10);
    reset_i = 1'b1;
    #1;
    check("rstm_valid", 32'(evt_valid_o), 0);
    check("rstm_busy", 32'(busy_o), 0);
    check("rstm_idx", 32'(evt_idx_o), 0);
    check("rstm_ts", 32'(evt_ts_o), 0);
    check("rstm_err", 32'(err_cnt_o), 0);
    check("rstm_ack", 32'(ack_o), 0);
    @(negedge clk_i);
    reset_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      check("rstm_no_ack", 32'(ack_o), 0);
    end
    idle_cycles(4);

    // Timestamp wrap: grant while the counter reads 15.
    for (int n = 0; n < 40 && (cyc % 16) != 15; n++) @(negedge clk_i);
    req_i[9] = 2'b10;
    @(negedge clk_i);
    check("ts_first_valid", 32'(evt_valid_o), 1);
    check("ts_first", 32'(evt_ts_o), 15);
    repeat (3) @(negedge clk_i);
    check("ts_second_valid", 32'(evt_valid_o), 1);
    check("ts_second", 32'(evt_ts_o), 2);
    idle_cycles(4);

    // Enable dropped during SEND: event completes, then no further grants.
    evt_ready_i = 1'b0;
    req_i[6] = 2'b10;
    wait_valid("en_valid", 10);
    enable_i = 1'b0;
    evt_ready_i = 1'b1;
    @(negedge clk_i);
    check("en_ack", 32'(ack_o), 32'h0040);
    repeat (8) begin
      @(negedge clk_i);
      check("en_no_grant", 32'(evt_valid_o), 0);
    end
    enable_i = 1'b1;
    wait_valid("en_resume", 10);
    check("en_resume_idx", 32'(evt_idx_o), 6);
    idle_cycles(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
